// File: rtl/conv_pkg.sv
// conv_pkg
// Shared definitions for the result buffer writer.
//   state_t               capture FSM states (IDLE, WRITE, DONE)
//   DEFAULT_DATA_WIDTH    default width of one stored sample
//   DEFAULT_ADDRESS_WIDTH default buffer address width (depth = 2**width)
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_DATA_WIDTH    = 16;
    localparam int DEFAULT_ADDRESS_WIDTH = 5;

endpackage : conv_pkg

// File: rtl/sync_ram.sv
// sync_ram
// Single-clock buffer with one write port and one registered read port.
// The array itself has no reset, so its contents survive rst_n; only the
// read register is cleared.
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset (read register only)
//   wr_en_i    write strobe
//   wr_addr_i  write address
//   wr_data_i  write data
//   rd_addr_i  read address
//   rd_data_o  mem[rd_addr_i] from the previous cycle
module sync_ram
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en_i,
    input  logic [ADDRESS_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0]    wr_data_i,
    input  logic [ADDRESS_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0]    rd_data_o
);

    localparam int DEPTH = 1 << ADDRESS_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Non-blocking update of the array means a read of the address being
    // written this cycle still returns the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule : sync_ram

// File: rtl/result_buffer_writer.sv
// result_buffer_writer
// Captures a run of up to 2**ADDRESS_WIDTH samples from a valid/ready
// stream into a buffer, starting at address 0, and offers registered
// random-access readback at any time.
//   clk      clock, rising edge
//   rst_n    asynchronous active-low reset
//   start    one-cycle pulse: latch len and (re)start a capture run
//   len      samples to capture, clamped to the buffer depth
//   s_valid  producer has a sample on s_data
//   s_data   sample value
//   s_ready  a sample is accepted this cycle
//   rd_addr  readback address
//   rd_data  readback data, one cycle after rd_addr
//   busy     capture run in progress
//   done     capture run finished, waiting for the next start
//   count    samples written in the current or last run
module result_buffer_writer
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH:0]   len,
    input  logic                     s_valid,
    input  logic [DATA_WIDTH-1:0]    s_data,
    output logic                     s_ready,
    input  logic [ADDRESS_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     busy,
    output logic                     done,
    output logic [ADDRESS_WIDTH:0]   count
);

    localparam logic [ADDRESS_WIDTH:0] DEPTH = {1'b1, {ADDRESS_WIDTH{1'b0}}};
    localparam logic [ADDRESS_WIDTH:0] ONE   = {{ADDRESS_WIDTH{1'b0}}, 1'b1};

    state_t                 state_q;
    logic [ADDRESS_WIDTH:0] count_q;
    logic [ADDRESS_WIDTH:0] len_q;

    logic [ADDRESS_WIDTH:0] len_clamped_d;
    logic [ADDRESS_WIDTH:0] count_inc_d;
    logic                   wr_en;

    assign len_clamped_d = (len > DEPTH) ? DEPTH : len;
    assign count_inc_d   = count_q + ONE;

    // start takes priority over any sample offered in the same cycle.
    assign s_ready = (state_q == WRITE) && !start;
    assign wr_en   = s_valid && s_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            len_q   <= '0;
        end else if (start) begin
            // Restart from address 0 in any state; words from an aborted
            // run stay in the buffer.
            len_q   <= len_clamped_d;
            count_q <= '0;
            state_q <= (len_clamped_d == '0) ? DONE : WRITE;
        end else begin
            case (state_q)
                IDLE: ;
                WRITE: begin
                    // Leaving WRITE on the last sample keeps count at len_q
                    // and the write address inside the buffer.
                    if (s_valid) begin
                        count_q <= count_inc_d;
                        if (count_inc_d == len_q) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: ;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy  = (state_q == WRITE);
    assign done  = (state_q == DONE);
    assign count = count_q;

    sync_ram #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (wr_en),
        .wr_addr_i (count_q[ADDRESS_WIDTH-1:0]),
        .wr_data_i (s_data),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

endmodule : result_buffer_writer

// File: tb/tb_result_buffer_writer.sv
module tb_result_buffer_writer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [5:0]  len;
    logic        s_valid;
    logic [15:0] s_data;
    logic        s_ready;
    logic [4:0]  rd_addr;
    logic [15:0] rd_data;
    logic        busy;
    logic        done;
    logic [5:0]  count;

    int total = 0;
    int bad   = 0;
    int step  = 0;

    typedef struct {
        logic        start;
        logic [5:0]  len;
        logic        sv;
        logic [15:0] sd;
        logic [4:0]  ra;
        logic        rdy;   // s_ready before the edge
        logic        busy;  // after the edge
        logic        done;
        logic [5:0]  cnt;
        logic        ck;    // check rd_data after the edge
        logic [15:0] rd;
    } vec_t;

    vec_t tbl[$];

    result_buffer_writer #(
        .DATA_WIDTH    (16),
        .ADDRESS_WIDTH (5)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .len     (len),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ready (s_ready),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .busy    (busy),
        .done    (done),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(int st, int ln, int sv, int sd, int ra,
                                int rdy, int bsy, int dn, int cnt, int ck, int rd);
        vec_t v;
        v.start = st[0];
        v.len   = ln[5:0];
        v.sv    = sv[0];
        v.sd    = sd[15:0];
        v.ra    = ra[4:0];
        v.rdy   = rdy[0];
        v.busy  = bsy[0];
        v.done  = dn[0];
        v.cnt   = cnt[5:0];
        v.ck    = ck[0];
        v.rd    = rd[15:0];
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL step%0d %s: got %h want %h", step, nm, act, exp);
        end
    endtask

    // Called 1 time unit after a rising edge: drive, check s_ready, clock, check state.
    task automatic apply(input vec_t v);
        start   = v.start;
        len     = v.len;
        s_valid = v.sv;
        s_data  = v.sd;
        rd_addr = v.ra;
        #1;
        chk("s_ready", 32'(s_ready), 32'(v.rdy));
        @(posedge clk);
        #1;
        chk("busy", 32'(busy), 32'(v.busy));
        chk("done", 32'(done), 32'(v.done));
        chk("count", 32'(count), 32'(v.cnt));
        if (v.ck) chk("rd_data", 32'(rd_data), 32'(v.rd));
        step++;
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        len     = '0;
        s_valid = 1'b0;
        s_data  = '0;
        rd_addr = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        //             st ln sv sd       ra  rdy b d cnt ck rd
        // len=4 back-to-back, then readback
        tbl.push_back(mk(1, 4, 0, 0,       0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 'h0011,  0, 1, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 'h0022,  0, 1, 1, 0, 2, 0, 0));
        tbl.push_back(mk(0, 0, 1, 'h0033,  0, 1, 1, 0, 3, 0, 0));
        tbl.push_back(mk(0, 0, 1, 'h0044,  0, 1, 0, 1, 4, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,       0, 0, 0, 1, 4, 1, 'h0011));
        tbl.push_back(mk(0, 0, 0, 0,       1, 0, 0, 1, 4, 1, 'h0022));
        tbl.push_back(mk(0, 0, 0, 0,       2, 0, 0, 1, 4, 1, 'h0033));
        tbl.push_back(mk(0, 0, 0, 0,       3, 0, 0, 1, 4, 1, 'h0044));
        // len=3 with gaps in s_valid, extra s_valid in DONE
        tbl.push_back(mk(1, 3, 0, 0,       3, 0, 1, 0, 0, 1, 'h0044));
        tbl.push_back(mk(0, 0, 1, 'h00A1,  3, 1, 1, 0, 1, 1, 'h0044));
        tbl.push_back(mk(0, 0, 0, 0,       3, 1, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 'h00A2,  3, 1, 1, 0, 2, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,       3, 1, 1, 0, 2, 0, 0));
        tbl.push_back(mk(0, 0, 1, 'h00A3,  3, 1, 0, 1, 3, 0, 0));
        tbl.push_back(mk(0, 0, 1, 'h0BAD,  3, 0, 0, 1, 3, 1, 'h0044));
        tbl.push_back(mk(0, 0, 1, 'h0BAD,  0, 0, 0, 1, 3, 1, 'h00A1));
        tbl.push_back(mk(0, 0, 0, 0,       2, 0, 0, 1, 3, 1, 'h00A3));
        // len=0 goes straight to DONE
        tbl.push_back(mk(1, 0, 1, 'h1111,  1, 0, 0, 1, 0, 1, 'h00A2));
        tbl.push_back(mk(0, 0, 1, 'h1111,  3, 0, 0, 1, 0, 1, 'h0044));
        tbl.push_back(mk(0, 0, 0, 0,       0, 0, 0, 1, 0, 1, 'h00A1));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // len=40 clamps to 32
        apply(mk(1, 40, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        for (int i = 0; i < 32; i++) begin
            apply(mk(0, 0, 1, 'h5000 + i, 0, 1, (i == 31) ? 0 : 1, (i == 31) ? 1 : 0,
                     i + 1, 0, 0));
        end
        apply(mk(0, 0, 1, 'hFFFF, 31, 0, 0, 1, 32, 1, 'h501F));
        apply(mk(0, 0, 0, 0,       0, 0, 0, 1, 32, 1, 'h5000));

        // start during WRITE with s_valid high at count=2
        apply(mk(1, 8, 0, 0,       0, 0, 1, 0, 0, 0, 0));
        apply(mk(0, 0, 1, 'h00C0,  0, 1, 1, 0, 1, 0, 0));
        apply(mk(0, 0, 1, 'h00C1,  0, 1, 1, 0, 2, 0, 0));
        apply(mk(1, 8, 1, 'hDEAD,  2, 0, 1, 0, 0, 1, 'h5002));
        apply(mk(0, 0, 1, 'h0077,  2, 1, 1, 0, 1, 1, 'h5002));
        apply(mk(0, 0, 0, 0,       0, 1, 1, 0, 1, 1, 'h0077));
        apply(mk(0, 0, 0, 0,       1, 1, 1, 0, 1, 1, 'h00C1));

        // asynchronous reset at count=5
        apply(mk(1, 8, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++) apply(mk(0, 0, 1, 'h00E0 + i, 0, 1, 1, 0, i + 1, 0, 0));
        start   = 1'b0;
        s_valid = 1'b1;
        s_data  = 16'hFFFF;
        rd_addr = 5'd0;
        #1;
        chk("pre_rst_s_ready", 32'(s_ready), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_done", 32'(done), 32'd0);
        chk("async_s_ready", 32'(s_ready), 32'd0);
        chk("async_count", 32'(count), 32'd0);
        chk("async_rd_data", 32'(rd_data), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) apply(mk(0, 0, 1, 'hFFFF, i, 0, 0, 0, 0, 1, 'h00E0 + i));

        // read and write of the same address in one cycle
        apply(mk(1, 3, 0, 0,       0, 0, 1, 0, 0, 0, 0));
        apply(mk(0, 0, 1, 'h1230,  0, 1, 1, 0, 1, 0, 0));
        apply(mk(0, 0, 1, 'h1231,  0, 1, 1, 0, 2, 0, 0));
        apply(mk(0, 0, 1, 'h1234,  0, 1, 0, 1, 3, 0, 0));
        apply(mk(1, 3, 0, 0,       2, 0, 1, 0, 0, 1, 'h1234));
        apply(mk(0, 0, 1, 'hAAA0,  2, 1, 1, 0, 1, 1, 'h1234));
        apply(mk(0, 0, 1, 'hAAA1,  2, 1, 1, 0, 2, 1, 'h1234));
        apply(mk(0, 0, 1, 'hBEEF,  2, 1, 0, 1, 3, 1, 'h1234));
        apply(mk(0, 0, 0, 0,       2, 0, 0, 1, 3, 1, 'hBEEF));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_result_buffer_writer
